// File: rtl/daq_rate_switch_seq.sv
// daq_rate_switch_seq: link-rate change sequencer (TX rate, divider init, PCS reset).
// Define DAQ_RATE_TMO_EN to enable the handshake timeout and the FAIL state.
module daq_rate_switch_seq #(
   parameter int NRATES   = 4,
   parameter int RST_RATE = 0,
   parameter int WAIT_CYC = 4,
   parameter int TMO_CYC  = 1023
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [2:0]        REQ_RATE,
   input  logic              TXRATEDONE,
   input  logic              CDV_DONE,
   output logic [2:0]        ACTIVE_RATE,
   output logic [NRATES-1:0] RATE_OH,
   output logic [2:0]        TX_RATE,
   output logic              CDV_INIT,
   output logic              PCSRST,
   output logic              BUSY,
   output logic              ERR,
   output logic [2:0]        SEQ_STATE
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REFCLK = 3'd1,
      WRDCLK = 3'd2,
      RSTCDV = 3'd3,
      RSTPCS = 3'd4,
      FAIL   = 3'd5
   } state_t;

`ifdef DAQ_RATE_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam logic [3:0] NR    = 4'(NRATES);
   localparam logic [2:0] RR    = 3'(RST_RATE);
   localparam logic [9:0] WLAST = 10'(WAIT_CYC - 1);
   localparam logic [9:0] TLIM  = 10'(TMO_CYC);

   state_t     state;
   state_t     nxt_state;
   logic [9:0] cnt;
   logic [9:0] nxt_cnt;
   logic [9:0] cnt_inc;
   logic [2:0] target;
   logic [2:0] nxt_target;
   logic [2:0] nxt_active;
   logic       req_ok;
   logic       tmo_hit;
   logic       switching;

   function automatic logic [NRATES-1:0] onehot(input logic [2:0] idx);
      logic [NRATES-1:0] v;
      v = '0;
      for (int i = 0; i < NRATES; i++) begin
         v[i] = (idx == 3'(i));
      end
      return v;
   endfunction

   assign cnt_inc = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;
   assign req_ok  = ({1'b0, REQ_RATE} < NR) && (REQ_RATE != ACTIVE_RATE);
   assign tmo_hit = TMO_EN && (cnt_inc >= TLIM);

   assign switching = (nxt_state == REFCLK) || (nxt_state == WRDCLK) ||
                      (nxt_state == RSTCDV) || (nxt_state == RSTPCS);

   // Next-state, counter, target and committed-rate decode.
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_target = target;
      nxt_active = ACTIVE_RATE;
      case (state)
         IDLE: begin
            if (req_ok) begin
               nxt_state  = REFCLK;
               nxt_target = REQ_RATE;
               nxt_cnt    = '0;
            end
         end
         REFCLK: begin
            if (TXRATEDONE) begin
               nxt_state = WRDCLK;
               nxt_cnt   = '0;
            end else if (tmo_hit) begin
               nxt_state = FAIL;
               nxt_cnt   = '0;
            end else if (TMO_EN) begin
               nxt_cnt = cnt_inc;
            end
         end
         WRDCLK: begin
            if (cnt >= WLAST) begin
               nxt_state = RSTCDV;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt_inc;
            end
         end
         RSTCDV: begin
            if (CDV_DONE) begin
               nxt_state = RSTPCS;
               nxt_cnt   = '0;
            end else if (tmo_hit) begin
               nxt_state = FAIL;
               nxt_cnt   = '0;
            end else if (TMO_EN) begin
               nxt_cnt = cnt_inc;
            end
         end
         RSTPCS: begin
            if (cnt >= WLAST) begin
               nxt_state  = IDLE;
               nxt_active = target;
               nxt_cnt    = '0;
            end else begin
               nxt_cnt = cnt_inc;
            end
         end
         FAIL: begin
            if (REQ_RATE == ACTIVE_RATE) begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         target      <= RR;
         ACTIVE_RATE <= RR;
         TX_RATE     <= RR;
         RATE_OH     <= onehot(RR);
         CDV_INIT    <= 1'b0;
         PCSRST      <= 1'b0;
         BUSY        <= 1'b0;
         ERR         <= 1'b0;
         SEQ_STATE   <= IDLE;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         target      <= nxt_target;
         ACTIVE_RATE <= nxt_active;
         TX_RATE     <= switching ? nxt_target : nxt_active;
         RATE_OH     <= (nxt_state == IDLE) ? onehot(nxt_active) : '0;
         CDV_INIT    <= (nxt_state == REFCLK) || (nxt_state == WRDCLK);
         PCSRST      <= (nxt_state == RSTPCS);
         BUSY        <= (nxt_state != IDLE);
         ERR         <= TMO_EN && (nxt_state == FAIL);
         SEQ_STATE   <= nxt_state;
      end
   end

endmodule

// File: tb/tb_daq_rate_switch_seq.sv
// tb_daq_rate_switch_seq: random rate switches against a phase-level model.
// A driver queues expected switches; a monitor checks each completed switch.
module tb_daq_rate_switch_seq;

   localparam int NR = 4;
   localparam int RR = 0;
   localparam int WC = 4;
   localparam int TC = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [2:0]    REQ_RATE = 3'(RR);
   logic          TXRATEDONE = 1'b0;
   logic          CDV_DONE = 1'b0;
   logic [2:0]    ACTIVE_RATE;
   logic [NR-1:0] RATE_OH;
   logic [2:0]    TX_RATE;
   logic          CDV_INIT;
   logic          PCSRST;
   logic          BUSY;
   logic          ERR;
   logic [2:0]    SEQ_STATE;

   int n_chk = 0;
   int n_fail = 0;
   int drv_active = RR;

   typedef struct {
      int tgt;
      int ref_len;
      int cdv_len;
      bit gap1;
      bit fail;
   } exp_t;

   exp_t q[$];

   always #5 CLK = ~CLK;

   daq_rate_switch_seq #(
      .NRATES(NR), .RST_RATE(RR), .WAIT_CYC(WC), .TMO_CYC(TC)
   ) dut (
      .CLK(CLK), .RST(RST), .REQ_RATE(REQ_RATE),
      .TXRATEDONE(TXRATEDONE), .CDV_DONE(CDV_DONE),
      .ACTIVE_RATE(ACTIVE_RATE), .RATE_OH(RATE_OH), .TX_RATE(TX_RATE),
      .CDV_INIT(CDV_INIT), .PCSRST(PCSRST), .BUSY(BUSY), .ERR(ERR),
      .SEQ_STATE(SEQ_STATE)
   );

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (int'(SEQ_STATE) == s) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (int'(SEQ_STATE) == s) ok = 1'b1;
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_state: state %0d, required %0d within %0d cycles",
                  SEQ_STATE, s, bound);
      end
   endtask

   task automatic check_reset(input string name);
      check({name, "_state"}, int'(SEQ_STATE), 0);
      check({name, "_active"}, int'(ACTIVE_RATE), RR);
      check({name, "_tx"}, int'(TX_RATE), RR);
      check({name, "_oh"}, int'(RATE_OH), 1 << RR);
      check({name, "_busy"}, int'(BUSY), 0);
      check({name, "_cdvinit"}, int'(CDV_INIT), 0);
      check({name, "_pcsrst"}, int'(PCSRST), 0);
      check({name, "_err"}, int'(ERR), 0);
   endtask

   // One complete switch: request, TX done after dref, divider done after dcdv.
   task automatic do_switch(input int rate, input int dref, input int dcdv,
                            input int nxt);
      exp_t e;
      bit   ok;
      @(negedge CLK);
      e.tgt     = rate;
      e.ref_len = dref;
      e.cdv_len = dcdv;
      e.fail    = 1'b0;
      e.gap1    = (SEQ_STATE != 3'd0);
      q.push_back(e);
      REQ_RATE   = 3'(rate);
      TXRATEDONE = 1'($urandom_range(0, 1));
      CDV_DONE   = 1'($urandom_range(0, 1));
      drv_active = rate;
      @(negedge CLK);
      wait_state(1, 80, ok);
      if (!ok) return;
      TXRATEDONE = (dref == 0);
      CDV_DONE   = 1'b0;
      for (int i = 1; i <= dref; i++) begin
         @(negedge CLK);
         TXRATEDONE = (i == dref);
      end
      @(negedge CLK);
      TXRATEDONE = 1'b0;
      for (int k = 0; k < 40 && SEQ_STATE != 3'd3; k++) begin
         CDV_DONE   = 1'($urandom_range(0, 1));
         TXRATEDONE = 1'($urandom_range(0, 1));
         REQ_RATE   = 3'($urandom_range(0, 7));
         @(negedge CLK);
      end
      wait_state(3, 1, ok);
      if (!ok) return;
      REQ_RATE   = 3'((nxt >= 0) ? nxt : rate);
      TXRATEDONE = 1'b0;
      CDV_DONE   = (dcdv == 0);
      for (int i = 1; i <= dcdv; i++) begin
         @(negedge CLK);
         CDV_DONE = (i == dcdv);
      end
      @(negedge CLK);
      CDV_DONE = 1'b0;
   endtask

   int cur = 0;
   int run = 0;
   int mon_active = RR;
   int len [8];

   // Monitor: phase lengths per switch, committed rate, per-cycle outputs.
   always @(negedge CLK) begin : mon
      int st;
      bit legal;
      exp_t e;
      logic [2:0] etx;
      logic [NR-1:0] eoh;
      logic [NR+9:0] act_v;
      logic [NR+9:0] exp_v;
      if (RST) begin
         q.delete();
         cur = 0;
         run = 0;
         mon_active = RR;
      end else begin
         st = int'(SEQ_STATE);
         if (st != cur) begin
            len[cur] = run;
            legal = (cur == 0 && st == 1) || (cur == 1 && st == 2) ||
                    (cur == 2 && st == 3) || (cur == 3 && st == 4) ||
                    (cur == 4 && st == 0) || (cur == 1 && st == 5) ||
                    (cur == 3 && st == 5) || (cur == 5 && st == 0);
            n_chk++;
            if (!legal) begin
               n_fail++;
               $display("FAIL state_step: went %0d -> %0d", cur, st);
            end
            if (cur == 0 && st == 1) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_switch: state 1, required 0 (no request)");
               end else if (q[0].gap1) begin
                  check("idle_gap", run, 1);
               end
            end
            if ((cur == 4 && st == 0) || (cur == 1 && st == 5)) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_end: state %0d, no switch pending", st);
               end else begin
                  e = q.pop_front();
                  if (st == 5) begin
                     check("refclk_timeout_len", len[1], e.fail ? TC : -1);
                  end else begin
                     check("refclk_len", len[1], e.fail ? -1 : e.ref_len + 1);
                     check("wrdclk_len", len[2], WC);
                     check("rstcdv_len", len[3], e.cdv_len + 1);
                     check("rstpcs_len", len[4], WC);
                     mon_active = e.tgt;
                  end
               end
            end
            cur = st;
            run = 1;
         end else begin
            run++;
         end
         if (st >= 1 && st <= 4 && q.size() > 0) etx = 3'(q[0].tgt);
         else etx = 3'(mon_active);
         eoh = (st != 0) ? '0 : NR'(1 << mon_active);
         act_v = {BUSY, CDV_INIT, PCSRST, ERR, RATE_OH, ACTIVE_RATE, TX_RATE};
         exp_v = {st != 0, st == 1 || st == 2, st == 4, st == 5, eoh,
                  3'(mon_active), etx};
         n_chk++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs: state %0d got %h, required %h", st, act_v, exp_v);
         end
      end
   end

   initial begin
      bit ok;
      int r;
      exp_t e;
      repeat (3) @(negedge CLK);
      check_reset("reset");
      #1 RST = 1'b0;

      do_switch(2, 4, 2, -1);
      wait_state(0, 30, ok);
      @(negedge CLK);
      check("sw2_active", int'(ACTIVE_RATE), 2);
      check("sw2_oh", int'(RATE_OH), 4);

      REQ_RATE = 3'd5;
      repeat (6) @(negedge CLK);
      check("req5_ignored", int'(SEQ_STATE), 0);
      REQ_RATE = 3'(NR);
      repeat (6) @(negedge CLK);
      check("reqNR_ignored", int'(SEQ_STATE), 0);
      check("reqNR_active", int'(ACTIVE_RATE), 2);
      REQ_RATE = 3'd2;

      do_switch(0, 1, 1, -1);
      do_switch(1, 2, 3, 3);
      do_switch(3, 0, 0, -1);
      wait_state(0, 30, ok);
      @(negedge CLK);
      check("b2b_active", int'(ACTIVE_RATE), 3);

      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 8)) @(negedge CLK);
         if ($urandom_range(0, 3) == 0) begin
            REQ_RATE = 3'($urandom_range(NR, 7));
            repeat (2) @(negedge CLK);
         end
         r = $urandom_range(0, NR - 2);
         if (r >= drv_active) r++;
         do_switch(r, $urandom_range(0, 6), $urandom_range(0, 5), -1);
      end
      wait_state(0, 30, ok);

      r = (drv_active + 1) % NR;
`ifdef DAQ_RATE_TMO_EN
      @(negedge CLK);
      e.tgt = r;
      e.ref_len = 0;
      e.cdv_len = 0;
      e.gap1 = 1'b0;
      e.fail = 1'b1;
      q.push_back(e);
      REQ_RATE = 3'(r);
      TXRATEDONE = 1'b0;
      wait_state(5, TC + 10, ok);
      check("tmo_err", int'(ERR), 1);
      repeat (3) @(negedge CLK);
      check("fail_held", int'(SEQ_STATE), 5);
      REQ_RATE = 3'(drv_active);
      wait_state(0, 5, ok);
      check("fail_exit_err", int'(ERR), 0);
      do_switch(r, 1, 1, -1);
`else
      do_switch(r, 40, 1, -1);
`endif
      wait_state(0, 30, ok);

      r = (drv_active + 2) % NR;
      do_switch(r, 1, 1, -1);
      wait_state(4, 10, ok);
      #2 RST = 1'b1;
      #1 check_reset("rst_mid_pcs");
      REQ_RATE = 3'(RR);
      drv_active = RR;
      @(negedge CLK);
      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("post_rst_active", int'(ACTIVE_RATE), RR);

      do_switch(1, 0, 0, -1);
      wait_state(0, 30, ok);
      repeat (2) @(negedge CLK);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/daq_rate_switch_seq.md
DAQ_RATE_SWITCH_SEQ -- requirements
Module: daq_rate_switch_seq

Interface
REQ-001 SHALL have parameter NRATES, default 4: number of selectable link rates, 2..8.
REQ-002 SHALL have parameter RST_RATE, default 0: rate index active after reset, less than NRATES.
REQ-003 SHALL have parameter WAIT_CYC, default 4: hold length, 1..15 cycles, for the word-clock settle and PCS-reset phases.
REQ-004 SHALL have parameter TMO_CYC, default 1023: handshake timeout limit in cycles, 1..1023.
REQ-005 SHALL have port CLK, input, 1: clock.
REQ-006 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port REQ_RATE, input, 3: requested rate index, level-sensitive.
REQ-008 SHALL have port TXRATEDONE, input, 1: transceiver rate-change done.
REQ-009 SHALL have port CDV_DONE, input, 1: clock-divider reset done.
REQ-010 SHALL have port ACTIVE_RATE, output, 3: index of the rate currently in force.
REQ-011 SHALL have port RATE_OH, output, NRATES: one-hot of ACTIVE_RATE; all zero while BUSY.
REQ-012 SHALL have port TX_RATE, output, 3: index driven to the transceiver; equals the target index from REFCLK onward.
REQ-013 SHALL have port CDV_INIT, PCSRST, BUSY, ERR, output, 1 each: divider init, PCS reset, switch in progress, handshake failure.
REQ-014 SHALL have port SEQ_STATE, output, 3: state encoding, for debug.

Function
REQ-015 SHALL implement states IDLE=0, REFCLK=1, WRDCLK=2, RSTCDV=3, RSTPCS=4, FAIL=5; all other codes SHALL go to IDLE.
REQ-016 In IDLE: if REQ_RATE differs from ACTIVE_RATE and REQ_RATE < NRATES, SHALL latch REQ_RATE into TARGET, go to REFCLK and clear the internal counter.
REQ-017 A REQ_RATE value of NRATES or above SHALL be ignored: stay in IDLE, no output change.
REQ-018 In REFCLK: TX_RATE=TARGET and CDV_INIT=1; on TXRATEDONE go to WRDCLK and clear the counter.
REQ-019 In WRDCLK: CDV_INIT=1 and the counter increments; once the counter reaches WAIT_CYC-1, go to RSTCDV.
REQ-020 In RSTCDV: wait for CDV_DONE, then go to RSTPCS and clear the counter.
REQ-021 In RSTPCS: PCSRST=1 for exactly WAIT_CYC cycles; then ACTIVE_RATE<=TARGET and go to IDLE.
REQ-022 BUSY SHALL be 1 in every state except IDLE.
REQ-023 All outputs SHALL be registered and decoded from the next state, so an output is valid in the same cycle the state register enters that state.
REQ-024 REQ_RATE changes during a switch SHALL be ignored until IDLE; in IDLE a request differing from ACTIVE_RATE SHALL immediately start a new switch (back-to-back allowed, IDLE lasts 1 cycle).
REQ-025 TXRATEDONE or CDV_DONE asserted outside its waiting state SHALL be ignored.
REQ-026 If TXRATEDONE and the REFCLK entry occur in the same cycle, the done SHALL count only in the next cycle (no zero-cycle REFCLK).
REQ-027 The counter SHALL be 10 bits and SHALL saturate, never wrap.

Reset
REQ-028 On RST: state=IDLE, ACTIVE_RATE=TX_RATE=TARGET=RST_RATE, RATE_OH=one-hot(RST_RATE), counter=0, CDV_INIT=PCSRST=BUSY=ERR=0.
REQ-029 RST mid-switch SHALL abort immediately to the reset state; the partial switch SHALL leave no effect.

Configuration
REQ-030 With DAQ_RATE_TMO_EN defined: in REFCLK and RSTCDV the counter SHALL count wait cycles; reaching TMO_CYC SHALL go to FAIL.
REQ-031 FAIL SHALL hold ERR=1, BUSY=1, ACTIVE_RATE unchanged and TX_RATE=ACTIVE_RATE.
REQ-032 FAIL SHALL be left only when REQ_RATE equals ACTIVE_RATE, going to IDLE with ERR cleared; a new differing request SHALL then retry.
REQ-033 Without DAQ_RATE_TMO_EN: there SHALL be no timeout, FAIL SHALL be unreachable and ERR SHALL be constant 0.

Verification
REQ-034 Reset, REQ_RATE=0 -> IDLE, ACTIVE_RATE=0, RATE_OH=0001, BUSY=0.
REQ-035 REQ_RATE=2; TXRATEDONE 5 cycles later; CDV_DONE 3 cycles after WRDCLK exit -> WRDCLK 4 cycles, PCSRST 4 cycles, then ACTIVE_RATE=2, RATE_OH=0100, BUSY=0.
REQ-036 REQ_RATE=5 with NRATES=4 -> no state change.
REQ-037 REQ_RATE 0->1 then ->3 during RSTCDV -> switch to 1 completes, 1 IDLE cycle, then a switch to 3.
REQ-038 DAQ_RATE_TMO_EN with TMO_CYC=16, TXRATEDONE never asserted -> FAIL after 16 REFCLK cycles, ERR=1; REQ_RATE back to ACTIVE_RATE -> IDLE, ERR=0.
REQ-039 RST asserted in RSTPCS -> outputs return to their reset values asynchronously; ACTIVE_RATE=RST_RATE.
